pwm_duty_capture_ctrl: RTL and testbench

- Measures high time and period of one RC/servo PWM input in clk cycles.
- Sequences capture with a small FSM and exposes results through an Avalon-MM slave (Nios register map).
- Drives duty_out, the 32-bit word wired to the DUTY_IN PIO in_port.
- Fails safe: duty_out forced to 0 when the input goes silent.

---
 rtl/pwm_duty_capture_ctrl_if.sv | 32 +++
 rtl/pwm_duty_capture_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_pwm_duty_capture_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_duty_capture_ctrl_if.sv
// ============================================================================
// Module   : pwm_duty_capture_ctrl_if
// Brief    : Avalon-MM slave bus bundle for the PWM duty capture controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface pwm_duty_capture_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

`default_nettype wire

// File: rtl/pwm_duty_capture_ctrl.sv
// ============================================================================
// Module   : pwm_duty_capture_ctrl
// Brief    : Measures PWM high time and period, exposes them over Avalon-MM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pwm_duty_capture_ctrl #(
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 2500000
) (
  input  wire logic               clk,
  input  wire logic               reset_n,
  pwm_duty_capture_ctrl_if.slave  avs,
  input  wire logic               pwm_in,
  output logic                    irq,
  output logic [31:0]             duty_out
);

  localparam int              c_TW    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_TW-1:0] c_TLAST = c_TW'(TIMEOUT_CYCLES - 1);
  localparam logic [c_TW-1:0] c_TONE  = c_TW'(1);
  localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_RISE = 2'd1,
    S_HIGH      = 2'd2,
    S_LOW       = 2'd3
  } t_state;

  t_state            r_state;
  t_state            w_state_nxt;
  logic              r_s1, r_s2, r_s3;
  logic [CNT_W-1:0]  r_hcnt, r_pcnt, r_htmp;
  logic [CNT_W-1:0]  r_high, r_period;
  logic [c_TW-1:0]   r_tcnt;
  logic [1:0]        r_ctrl;
  logic [2:0]        r_status;
  logic [31:0]       r_readdata;
  logic              r_irq;

  logic              w_rise, w_fall, w_en, w_tmo, w_commit;
  logic              w_wr;
  logic [2:0]        w_w1c;
  logic [2:0]        w_status_nxt;
  logic [31:0]       w_rd_mux;

  function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : (v + c_ONE);
  endfunction

  assign w_rise = r_s2 & ~r_s3;
  assign w_fall = ~r_s2 & r_s3;
  assign w_en   = r_ctrl[0];
  assign w_wr   = avs.chipselect & ~avs.write_n;
  assign w_w1c  = (w_wr && avs.address == 2'd2) ? avs.writedata[2:0] : 3'b000;

  // Silence means no edge this cycle either, so an edge landing on the last count wins.
  assign w_tmo  = w_en && (r_state != S_IDLE) && !w_rise && !w_fall && (r_tcnt == c_TLAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE:      if (w_en) w_state_nxt = S_WAIT_RISE;
      S_WAIT_RISE: if (w_rise) w_state_nxt = S_HIGH;
      S_HIGH:      if (w_fall) w_state_nxt = S_LOW;
      S_LOW: begin
        if (w_rise) begin
          w_state_nxt = S_HIGH;
          w_commit    = 1'b1;
        end
      end
      default:     w_state_nxt = S_IDLE;
    endcase
    if (w_tmo) begin
      w_state_nxt = S_WAIT_RISE;
      w_commit    = 1'b0;
    end
    if (!w_en) begin
      w_state_nxt = S_IDLE;
      w_commit    = 1'b0;
    end
  end

  // Hardware sets are applied after the W1C mask so a coincident set survives.
  always_comb begin
    w_status_nxt = r_status & ~w_w1c;
    if (w_commit) begin
      w_status_nxt[0] = 1'b1;
      if (r_status[0]) w_status_nxt[2] = 1'b1;
    end
    if (w_tmo) begin
      w_status_nxt[1] = 1'b1;
      w_status_nxt[0] = 1'b0;
    end
  end

  always_comb begin
    w_rd_mux = 32'd0;
    case (avs.address)
      2'd0:    w_rd_mux = 32'(r_high);
      2'd1:    w_rd_mux = 32'(r_period);
      2'd2:    w_rd_mux = {29'd0, r_status};
      default: w_rd_mux = {30'd0, r_ctrl};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_s3       <= 1'b0;
      r_hcnt     <= '0;
      r_pcnt     <= '0;
      r_htmp     <= '0;
      r_tcnt     <= '0;
      r_high     <= '0;
      r_period   <= '0;
      r_ctrl     <= 2'b00;
      r_status   <= 3'b000;
      r_readdata <= 32'd0;
      r_irq      <= 1'b0;
    end else begin
      r_s1 <= pwm_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;

      if (!w_en || r_state == S_IDLE) begin
        r_hcnt <= '0;
        r_pcnt <= '0;
        r_tcnt <= '0;
      end else if (w_tmo) begin
        r_tcnt <= '0;
      end else begin
        r_tcnt <= (w_rise || w_fall) ? '0 : (r_tcnt + c_TONE);
        case (r_state)
          S_WAIT_RISE: begin
            if (w_rise) begin
              r_hcnt <= c_ONE;
              r_pcnt <= c_ONE;
            end
          end
          S_HIGH: begin
            if (w_fall) begin
              r_htmp <= r_hcnt;
            end else begin
              r_hcnt <= f_sat_inc(r_hcnt);
            end
            r_pcnt <= f_sat_inc(r_pcnt);
          end
          S_LOW: begin
            if (w_rise) begin
              r_hcnt <= c_ONE;
              r_pcnt <= c_ONE;
            end else begin
              r_pcnt <= f_sat_inc(r_pcnt);
            end
          end
          default: ;
        endcase
      end

      if (w_commit) begin
        r_high   <= r_htmp;
        r_period <= r_pcnt;
      end else if (w_tmo) begin
        r_high   <= '0;
        r_period <= '0;
      end

      if (w_wr && avs.address == 2'd3) r_ctrl <= avs.writedata[1:0];
      r_status   <= w_status_nxt;
      r_readdata <= avs.chipselect ? w_rd_mux : 32'd0;
      r_irq      <= r_ctrl[1] & (r_status[0] | r_status[1]);
    end
  end

  assign avs.readdata = r_readdata;
  assign irq          = r_irq;
  assign duty_out     = 32'(r_high);

endmodule

`default_nettype wire

// File: tb/tb_pwm_duty_capture_ctrl.sv
// ============================================================================
// Module   : tb_pwm_duty_capture_ctrl
// Brief    : Scoreboard bench for pwm_duty_capture_ctrl (32-bit and 8-bit builds).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pwm_duty_capture_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pwm_a = 1'b0, pwm_b = 1'b0;
  logic        irq_a, irq_b;
  logic [31:0] duty_a, duty_b;

  int run_a = 0, hi_a = 0, lo_a = 0, rises_a = 0;
  int run_b = 0, hi_b = 0, lo_b = 0, rises_b = 0;

  typedef struct {
    int          d;
    logic [31:0] exp;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  logic rd_a  = 1'b0, rd_b = 1'b0;

  always #5 clk = ~clk;

  pwm_duty_capture_ctrl_if ifa ();
  pwm_duty_capture_ctrl_if ifb ();

  pwm_duty_capture_ctrl #(.CNT_W(32), .TIMEOUT_CYCLES(200)) dut_a (
    .clk(clk), .reset_n(reset_n), .avs(ifa), .pwm_in(pwm_a), .irq(irq_a), .duty_out(duty_a)
  );

  pwm_duty_capture_ctrl #(.CNT_W(8), .TIMEOUT_CYCLES(1000)) dut_b (
    .clk(clk), .reset_n(reset_n), .avs(ifb), .pwm_in(pwm_b), .irq(irq_b), .duty_out(duty_b)
  );

  // PWM generators: edges land 1 time unit after a rising clk edge
  initial begin : g_gen_a
    forever begin
      if (run_a == 0) begin
        pwm_a = 1'b0;
        @(posedge clk); #1;
      end else begin
        pwm_a = 1'b1;
        rises_a++;
        for (int i = 0; i < hi_a && run_a != 0; i++) begin @(posedge clk); #1; end
        pwm_a = 1'b0;
        for (int i = 0; i < lo_a && run_a != 0; i++) begin @(posedge clk); #1; end
      end
    end
  end

  initial begin : g_gen_b
    forever begin
      if (run_b == 0) begin
        pwm_b = 1'b0;
        @(posedge clk); #1;
      end else begin
        pwm_b = 1'b1;
        rises_b++;
        for (int i = 0; i < hi_b && run_b != 0; i++) begin @(posedge clk); #1; end
        pwm_b = 1'b0;
        for (int i = 0; i < lo_b && run_b != 0; i++) begin @(posedge clk); #1; end
      end
    end
  end

  task automatic sb_check(input int d, input logic [31:0] act);
    exp_t x;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL unexpected_read dut=%0d got=%h", d, act);
    end else begin
      x = sb.pop_front();
      if (x.d != d || act !== x.exp) begin
        bad++;
        $display("FAIL %s dut=%0d got=%h want=%h", x.nm, d, act, x.exp);
      end
    end
  endtask

  // Monitor: a read accepted on a clk edge presents readdata by the next falling edge
  always @(posedge clk) begin
    rd_a <= ifa.chipselect & ifa.write_n;
    rd_b <= ifb.chipselect & ifb.write_n;
  end

  always @(negedge clk) begin
    if (rd_a) sb_check(0, ifa.readdata);
    if (rd_b) sb_check(1, ifb.readdata);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input int d, input logic [1:0] a, input logic [31:0] v);
    if (d == 0) begin
      ifa.chipselect = 1'b1; ifa.write_n = 1'b0; ifa.address = a; ifa.writedata = v;
    end else begin
      ifb.chipselect = 1'b1; ifb.write_n = 1'b0; ifb.address = a; ifb.writedata = v;
    end
    @(posedge clk); #1;
    ifa.chipselect = 1'b0; ifa.write_n = 1'b1;
    ifb.chipselect = 1'b0; ifb.write_n = 1'b1;
  endtask

  task automatic rd(input int d, input logic [1:0] a, input logic [31:0] e, input string nm);
    exp_t x;
    x.d = d; x.exp = e; x.nm = nm;
    sb.push_back(x);
    if (d == 0) begin
      ifa.chipselect = 1'b1; ifa.write_n = 1'b1; ifa.address = a;
    end else begin
      ifb.chipselect = 1'b1; ifb.write_n = 1'b1; ifb.address = a;
    end
    @(posedge clk); #1;
    ifa.chipselect = 1'b0;
    ifb.chipselect = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] e);
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, e);
    end
  endtask

  task automatic wait_rises(input int d, input int tgt);
    int n = 0;
    while (((d == 0) ? rises_a : rises_b) < tgt && n < 3000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 3000) begin
      bad++;
      $display("FAIL wait_rise dut=%0d got=%0d want=%0d", d, (d == 0) ? rises_a : rises_b, tgt);
    end
  endtask

  initial begin : g_watchdog
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin : g_main
    int base;
    ifa.chipselect = 1'b0; ifa.write_n = 1'b1; ifa.address = 2'd0; ifa.writedata = 32'd0;
    ifb.chipselect = 1'b0; ifb.write_n = 1'b1; ifb.address = 2'd0; ifb.writedata = 32'd0;
    cyc(3);
    reset_n = 1'b1;
    cyc(2);

    // Reset state
    rd(0, 2'd0, 32'd0, "rst_high");
    rd(0, 2'd1, 32'd0, "rst_period");
    rd(0, 2'd2, 32'd0, "rst_status");
    rd(0, 2'd3, 32'd0, "rst_control");
    rd(1, 2'd2, 32'd0, "rst_status_b");
    chk("rst_irq", {31'd0, irq_a}, 32'd0);
    chk("rst_duty", duty_a, 32'd0);

    // 30/70 capture; the third rise commits a second time and raises overrun
    wr(0, 2'd3, 32'hFFFF_FFFF);
    rd(0, 2'd3, 32'd3, "control_rw");
    hi_a = 30; lo_a = 70; run_a = 1;
    wait_rises(0, 3);
    cyc(10);
    rd(0, 2'd0, 32'd30, "high_30");
    rd(0, 2'd1, 32'd100, "period_100");
    rd(0, 2'd2, 32'd5, "status_valid_ovr");
    chk("duty_30", duty_a, 32'd30);
    chk("irq_valid", {31'd0, irq_a}, 32'd1);
    wr(0, 2'd0, 32'h0000_1234);
    wr(0, 2'd1, 32'h0000_5678);
    rd(0, 2'd0, 32'd30, "high_ro");
    rd(0, 2'd1, 32'd100, "period_ro");

    // W1C lands on the commit cycle: set wins, then a later W1C clears
    wait_rises(0, 4);
    cyc(2);
    wr(0, 2'd2, 32'd5);
    rd(0, 2'd2, 32'd5, "race_set_wins");
    wr(0, 2'd2, 32'd5);
    rd(0, 2'd2, 32'd0, "w1c_clears");

    // Silence after a fresh capture: timeout, then re-arm
    wait_rises(0, 5);
    cyc(10);
    run_a = 0;
    cyc(150);
    rd(0, 2'd2, 32'd1, "pre_timeout_status");
    rd(0, 2'd0, 32'd30, "pre_timeout_high");
    cyc(100);
    rd(0, 2'd2, 32'd2, "timeout_status");
    rd(0, 2'd0, 32'd0, "timeout_high");
    rd(0, 2'd1, 32'd0, "timeout_period");
    chk("timeout_duty", duty_a, 32'd0);
    chk("timeout_irq", {31'd0, irq_a}, 32'd1);
    wr(0, 2'd2, 32'd2);
    rd(0, 2'd2, 32'd0, "timeout_w1c");
    cyc(2);
    chk("irq_cleared", {31'd0, irq_a}, 32'd0);
    cyc(210);
    rd(0, 2'd2, 32'd2, "timeout_rearm");

    // Disable mid-HIGH, then re-enable: two rises needed before a commit
    wr(0, 2'd2, 32'd7);
    hi_a = 40; lo_a = 60; run_a = 1;
    base = rises_a;
    wait_rises(0, base + 1);
    cyc(10);
    wr(0, 2'd3, 32'd0);
    cyc(250);
    rd(0, 2'd2, 32'd0, "disabled_no_commit");
    rd(0, 2'd0, 32'd0, "disabled_high");
    base = rises_a;
    wait_rises(0, base + 1);
    cyc(10);
    wr(0, 2'd3, 32'd3);
    wait_rises(0, base + 2);
    cyc(10);
    rd(0, 2'd2, 32'd0, "reenable_first_rise");
    wait_rises(0, base + 3);
    cyc(10);
    rd(0, 2'd2, 32'd1, "reenable_valid");
    rd(0, 2'd0, 32'd40, "reenable_high");
    rd(0, 2'd1, 32'd100, "reenable_period");
    chk("reenable_duty", duty_a, 32'd40);
    run_a = 0;

    // 8-bit counters saturate at 255
    wr(1, 2'd3, 32'd3);
    hi_b = 260; lo_b = 40; run_b = 1;
    wait_rises(1, 2);
    cyc(10);
    rd(1, 2'd2, 32'd1, "sat_status");
    rd(1, 2'd0, 32'd255, "sat_high");
    rd(1, 2'd1, 32'd255, "sat_period");
    chk("sat_duty", duty_b, 32'd255);
    run_b = 0;

    cyc(5);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
